// File: rtl/pc_fetch_if.sv
// pc_fetch_if: bundles the redirect, hazard and instruction-memory handshake
// signals seen by the IF-stage fetch unit.
//   redirect_valid/redirect_pc : taken branch/jump from EX
//   stall                      : hazard-unit load-use stall
//   imem_busywait              : instruction memory not ready
//   imem_read/imem_addr        : instruction-memory read request and address
//   pc_out/pc_plus4            : fetch PC and its link value, to IF/ID
//   fetch_valid/flush          : IF/ID accept strobe, IF/ID + ID/EX clear
//   misalign_trap              : misaligned redirect target pulse
// master: the environment around the fetch unit; slave: the fetch unit.
interface pc_fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_busywait;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush;
    logic        misalign_trap;

    modport master (
        output redirect_valid, redirect_pc, stall, imem_busywait,
        input  imem_read, imem_addr, pc_out, pc_plus4, fetch_valid, flush,
               misalign_trap
    );

    modport slave (
        input  redirect_valid, redirect_pc, stall, imem_busywait,
        output imem_read, imem_addr, pc_out, pc_plus4, fetch_valid, flush,
               misalign_trap
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the architectural fetch PC, drives the instruction-memory
// read handshake and raises the IF/ID + ID/EX flush on accepted redirects.
// Ports:
//   CLK   : system clock, rising edge
//   RESET : asynchronous active-low reset
//   bus   : pc_fetch_if.slave (redirect, stall, imem handshake, IF/ID outputs)
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned redirect targets are refused and raise a registered
//               one-cycle misalign_trap pulse
//   undefined : redirect_pc[1:0] is forced to 2'b00, misalign_trap tied 0
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    pc_fetch_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;

    logic        redirect_ok;
    logic        redirect_bad;
    logic [31:0] target;

    logic        imem_read;
    logic        fetch_valid;
    logic        flush;

`ifdef MISALIGN_TRAP_EN
    logic        trap_q;

    // Misaligned targets are refused outright.
    assign redirect_bad = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
    assign redirect_ok  = bus.redirect_valid & ~redirect_bad;
    assign target       = bus.redirect_pc;

    // Trap pulse lands the cycle after the offending request; IDLE ignores it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= redirect_bad & (state_q != IDLE);
        end
    end

    assign bus.misalign_trap = trap_q;
`else
    // Low target bits are dropped so the PC stays word aligned.
    assign redirect_bad      = 1'b0;
    assign redirect_ok       = bus.redirect_valid;
    assign target            = bus.redirect_pc & ~32'h0000_0003;
    assign bus.misalign_trap = 1'b0;
`endif

    // State, PC and pending-target registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            pend_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state, next-PC and handshake outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        imem_read   = 1'b0;
        fetch_valid = 1'b0;
        flush       = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = RUN;
            end

            RUN: begin
                imem_read = 1'b1;
                if (redirect_ok && !bus.imem_busywait) begin
                    // Wrong-path word is dropped; refetch from target.
                    pc_d  = target;
                    flush = 1'b1;
                end else if (redirect_ok) begin
                    // Read in flight: park the target until it completes.
                    pend_d  = target;
                    flush   = 1'b1;
                    state_d = DISCARD;
                end else if (redirect_bad || bus.stall || bus.imem_busywait) begin
                    // Hold the PC: refused redirect, load-use stall or busy memory.
                    pc_d = pc_q;
                end else begin
                    fetch_valid = 1'b1;
                    pc_d        = pc_q + 32'(PC_STEP);
                end
            end

            DISCARD: begin
                imem_read = 1'b1;
                if (redirect_ok) begin
                    pend_d = target;
                    flush  = 1'b1;
                end
                if (!bus.imem_busywait) begin
                    pc_d    = redirect_ok ? target : pend_q;
                    state_d = RUN;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.imem_read   = imem_read;
    assign bus.fetch_valid = fetch_valid;
    assign bus.flush       = flush;
    assign bus.imem_addr   = pc_q;
    assign bus.pc_out      = pc_q;
    assign bus.pc_plus4    = pc_q + 32'(PC_STEP);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scoreboard bench for pc_fetch_unit. Each step
// drives the inputs, pushes the expected outputs for that cycle and pops them
// for comparison on the falling edge.
module tb_pc_fetch_unit;

    typedef struct {
        string       tag;
        logic        rd;
        logic [31:0] addr;
        logic        fv;
        logic        fl;
        logic        tr;
    } exp_t;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;
    exp_t sb[$];

    pc_fetch_if bus ();

    pc_fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .PC_STEP      (4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    task automatic compare_top();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            check(e.tag, "imem_read",     32'(bus.imem_read),     32'(e.rd));
            check(e.tag, "imem_addr",     bus.imem_addr,          e.addr);
            check(e.tag, "pc_out",        bus.pc_out,             e.addr);
            check(e.tag, "pc_plus4",      bus.pc_plus4,           e.addr + 32'd4);
            check(e.tag, "fetch_valid",   32'(bus.fetch_valid),   32'(e.fv));
            check(e.tag, "flush",         32'(bus.flush),         32'(e.fl));
            check(e.tag, "misalign_trap", 32'(bus.misalign_trap), 32'(e.tr));
        end
    endtask

    // One clock cycle: drive, expect, compare at negedge, advance past posedge.
    task automatic step(input string tag, input logic rv, input logic [31:0] rpc,
                        input logic st, input logic bw,
                        input logic e_rd, input logic [31:0] e_addr,
                        input logic e_fv, input logic e_fl, input logic e_tr);
        exp_t e;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.stall          = st;
        bus.imem_busywait  = bw;
        e.tag = tag; e.rd = e_rd; e.addr = e_addr; e.fv = e_fv; e.fl = e_fl; e.tr = e_tr;
        sb.push_back(e);
        @(negedge CLK);
        compare_top();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        CLK    = 1'b0;
        RESET  = 1'b0;
        checks = 0;
        errors = 0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.stall          = 1'b0;
        bus.imem_busywait  = 1'b0;

        // Reset state.
        #12;
        sb.push_back('{tag: "reset", rd: 1'b0, addr: 32'h0, fv: 1'b0, fl: 1'b0, tr: 1'b0});
        compare_top();
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;

        // 1: IDLE then sequential fetch.
        step("idle",   0, 32'h0, 0, 0,  0, 32'h00, 0, 0, 0);
        step("seq0",   0, 32'h0, 0, 0,  1, 32'h00, 1, 0, 0);
        step("seq4",   0, 32'h0, 0, 0,  1, 32'h04, 1, 0, 0);
        step("seq8",   0, 32'h0, 0, 0,  1, 32'h08, 1, 0, 0);
        step("seq12",  0, 32'h0, 0, 0,  1, 32'h0C, 1, 0, 0);

        // 2: redirect without busywait.
        step("rd_80",  1, 32'h80, 0, 0, 1, 32'h10, 0, 1, 0);
        step("at_80",  0, 32'h0, 0, 0,  1, 32'h80, 1, 0, 0);

        // 3: redirect while busy, DISCARD holds the address.
        step("to_20",  1, 32'h20, 0, 0, 1, 32'h84, 0, 1, 0);
        step("bw_rd",  1, 32'h100, 0, 1, 1, 32'h20, 0, 1, 0);
        step("disc1",  0, 32'h0, 0, 1,  1, 32'h20, 0, 0, 0);
        step("disc2",  0, 32'h0, 0, 1,  1, 32'h20, 0, 0, 0);
        step("disc_e", 0, 32'h0, 0, 0,  1, 32'h20, 0, 0, 0);
        step("at_100", 0, 32'h0, 0, 0,  1, 32'h100, 1, 0, 0);

        // 4: newest pending redirect wins.
        step("bw_r1",  1, 32'h100, 0, 1, 1, 32'h104, 0, 1, 0);
        step("bw_r2",  1, 32'h200, 0, 1, 1, 32'h104, 0, 1, 0);
        step("disc_e", 0, 32'h0, 0, 0,  1, 32'h104, 0, 0, 0);
        step("at_200", 0, 32'h0, 0, 0,  1, 32'h200, 1, 0, 0);

        // 5: redirect outranks stall; stall alone holds.
        step("to_40",  1, 32'h40, 0, 0, 1, 32'h204, 0, 1, 0);
        step("st_rd",  1, 32'h60, 1, 0, 1, 32'h40, 0, 1, 0);
        step("at_60",  0, 32'h0, 0, 0,  1, 32'h60, 1, 0, 0);
        step("to_44",  1, 32'h44, 0, 0, 1, 32'h64, 0, 1, 0);
        step("stall1", 0, 32'h0, 1, 0,  1, 32'h44, 0, 0, 0);
        step("stall2", 0, 32'h0, 1, 0,  1, 32'h44, 0, 0, 0);
        step("at_44",  0, 32'h0, 0, 0,  1, 32'h44, 1, 0, 0);

        // 6: misaligned redirect target.
`ifdef MISALIGN_TRAP_EN
        step("mis_rd", 1, 32'h102, 0, 0, 1, 32'h48, 0, 0, 0);
        step("mis_tr", 0, 32'h0, 0, 0,   1, 32'h48, 1, 0, 1);
        step("mis_e",  0, 32'h0, 0, 0,   1, 32'h4C, 1, 0, 0);
`else
        step("mis_rd", 1, 32'h102, 0, 0, 1, 32'h48, 0, 1, 0);
        step("mis_at", 0, 32'h0, 0, 0,   1, 32'h100, 1, 0, 0);
        step("mis_e",  0, 32'h0, 0, 0,   1, 32'h104, 1, 0, 0);
`endif

        // Wrap-around at the top of the address space.
        step("to_top", 1, 32'hFFFF_FFFC, 0, 0, 1, sb_next_addr(), 0, 1, 0);
        step("top",    0, 32'h0, 0, 0,  1, 32'hFFFF_FFFC, 1, 0, 0);
        step("wrap",   0, 32'h0, 0, 0,  1, 32'h0000_0000, 1, 0, 0);

        // Async reset in the middle of DISCARD drops the pending target.
        step("bw_r3",  1, 32'h300, 0, 1, 1, 32'h04, 0, 1, 0);
        bus.redirect_valid = 1'b0;
        #2;
        RESET = 1'b0;
        sb.push_back('{tag: "rst_mid", rd: 1'b0, addr: 32'h0, fv: 1'b0, fl: 1'b0, tr: 1'b0});
        @(negedge CLK);
        compare_top();
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        step("idle_rd", 1, 32'h500, 0, 0, 0, 32'h00, 0, 0, 0);
        step("run0",    0, 32'h0, 0, 1,   1, 32'h00, 0, 0, 0);
        step("run0b",   0, 32'h0, 0, 0,   1, 32'h00, 1, 0, 0);
        step("run4",    0, 32'h0, 0, 0,   1, 32'h04, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Address reached after the misaligned-redirect section in each build.
    function automatic logic [31:0] sb_next_addr();
`ifdef MISALIGN_TRAP_EN
        return 32'h50;
`else
        return 32'h108;
`endif
    endfunction

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Other end of the branch/jump resolution interface. Consumes the redirect request (taken/jump flag and target PC) and owns the architectural fetch PC.
- Drives the instruction-memory read handshake and the IF/ID + ID/EX flush.
- Sits in the IF stage between the hazard unit, instruction memory and the IF/ID pipeline register.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  taken branch or jump from the EX-stage branch/jump unit.
- redirect_pc  input  32  target PC, valid when redirect_valid=1.
- stall  input  1  hazard-unit stall (load-use); hold the PC.
- imem_busywait  input  1  instruction memory not ready; read must be held.
- imem_read  output  1  instruction-memory read request.
- imem_addr  output  32  fetch address; always equals pc_q.
- pc_out  output  32  PC of the fetched instruction, to IF/ID.
- pc_plus4  output  32  pc_q + PC_STEP, for JAL/JALR link.
- fetch_valid  output  1  instruction accepted into IF/ID this cycle.
- flush  output  1  clears IF/ID and ID/EX at the next edge.
- misalign_trap  output  1  misaligned redirect target (feature only; tied 0 otherwise).

Behaviour:
- Reset (RESET=0, async):
  - pc_q=RESET_VECTOR, pending target pend_q=0, state=IDLE.
  - All 1-bit outputs 0.
  - pc_out tracks pc_q (combinational).
- States:
  - IDLE: imem_read=0, no fetch. Always goes to RUN on the first edge after reset release. Inputs are ignored, including redirect.
  - RUN: imem_read=1. Evaluated in priority order:
    1. redirect_valid & ~imem_busywait: pc_q<=redirect_pc; flush=1; fetch_valid=0, so the wrong-path word is dropped; stay RUN.
    2. redirect_valid & imem_busywait: pend_q<=redirect_pc; flush=1; go to DISCARD.
    3. stall: pc_q holds; fetch_valid=0; imem_read stays 1.
    4. imem_busywait: pc_q holds; fetch_valid=0.
    5. Otherwise: fetch_valid=1; pc_q<=pc_q+PC_STEP.
  - DISCARD: waits for the in-flight wrong-path read to complete without delivering it.
    - imem_read=1, fetch_valid=0.
    - redirect_valid in DISCARD: pend_q<=redirect_pc (newest wins); flush=1.
    - imem_busywait=0: pc_q<=(redirect_valid ? redirect_pc : pend_q); go to RUN.
- Redirect always outranks stall; a stall never masks a flush.
- flush is combinational, a single cycle per accepted redirect. There is no flush in IDLE.
- Arithmetic is modulo 2^32: pc_q=32'hFFFF_FFFC increments to 32'h0000_0000.
- imem_addr never changes while imem_busywait=1 within a request. The only exception is the DISCARD-to-RUN edge after the read completes.
- Async reset mid-DISCARD discards pend_q and returns to IDLE.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - redirect_pc[1:0]!=0 is not taken: pc_q and state are unchanged and flush=0.
  - misalign_trap pulses 1 for one cycle, registered, i.e. the cycle after the request.
  - This applies in both RUN and DISCARD. In DISCARD the prior pend_q is kept.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 before use.
  - misalign_trap is tied 0.

Test Plan:
1. Reset release, RESET_VECTOR=0, no busywait: cycle 1 imem_read=0. Then fetch_valid=1 each cycle with imem_addr 0,4,8,12.
2. RUN at pc=0x10, redirect_valid=1, redirect_pc=0x80, busywait=0: flush=1 and fetch_valid=0 that cycle; next cycle imem_addr=0x80.
3. pc=0x20, busywait=1 for 3 cycles, redirect to 0x100 in cycle 1: flush=1 once. DISCARD with imem_addr=0x20 held, fetch_valid=0 throughout. After busywait drops, imem_addr=0x100.
4. DISCARD pending 0x100, second redirect to 0x200 while busy: flush=1 again. Resumes at 0x200, not 0x100.
5. stall=1 and redirect_valid=1 together at pc=0x40 to 0x60: redirect taken, flush=1, next imem_addr=0x60. stall alone for 2 cycles: imem_addr stays 0x44, fetch_valid=0.
6. MISALIGN_TRAP_EN defined, redirect_pc=0x102: no flush, pc unchanged, misalign_trap=1 for exactly one cycle. Without the macro: next imem_addr=0x100, misalign_trap=0.
